morse_rx_decoder: RTL and testbench
===================================

// Module: morse_rx_decoder
// PURPOSE
//  Receive side of the 2 m Morse link: samples an on/off keyed envelope (e.g. receiver squelch/CW detector on a PMOD pin),
//  times marks and spaces against a programmable dot length, and decodes elements into ASCII characters.
//  Decoded bytes are queued in a small FIFO for readback over the SPI command path.
// PARAMETERS
//  TICK_DIV        36000  clk cycles per timing tick (1 kHz at 36 MHz)
//  DEBOUNCE_TICKS  4      ticks the synchronised key level must be stable before being accepted
//  FIFO_DEPTH      16     decoded-character FIFO entries (power of two)
// PORTS
//  clk          in   1   system clock, PLL GENCLK domain
//  rst          in   1   asynchronous, active-high reset
//  key_in       in   1   raw keyed envelope, asynchronous; 1 = carrier present (mark)
//  enable       in   1   1 = decode; 0 = hold decoder idle, discard partial symbol (FIFO kept)
//  dot_ticks    in   12  dot length in ticks; 0 treated as 1
//  out_data     out  8   ASCII head of FIFO (first-word fall-through)
//  out_valid    out  1   FIFO non-empty
//  out_ready    in   1   pop head when out_valid & out_ready
//  overrun      out  1   sticky: a character was dropped because FIFO was full
//  clr_overrun  in   1   one-cycle pulse clears overrun
//  busy         out  1   state != IDLE
// BEHAVIOUR
//  - Reset: all outputs 0; counters, symbol register, FIFO pointers cleared; state IDLE. Reset mid-character discards it.
//  - key_in -> 2-FF synchroniser -> debouncer (accepts new level after DEBOUNCE_TICKS consecutive equal tick samples).
//    Both edges delayed equally, so durations are preserved; single-tick glitches never reach the decoder.
//  - Prescaler emits a 1-cycle tick every TICK_DIV clks. dur counter (16 b) counts ticks since last accepted edge,
//    cleared on each edge, saturates at 16'hFFFF. Thresholds D=max(dot_ticks,1): 2D, 3D, 7D (max 28665, fits 16 b).
//  - Symbol register: sym_bits[5:0], sym_len[2:0], sym_err. Element appended MSB-first: dot=0, dash=1.
//  - FSM:
//    IDLE    : key=0, nothing pending. key rise -> MARK (dur=0).
//    MARK    : key fall -> classify: dur < 2D dot, else dash. sym_len==6 -> set sym_err instead of appending. -> GAP.
//    GAP     : key rise before 3D -> MARK (same character). dur reaches 3D -> push char, clear symbol -> WORDGAP.
//    WORDGAP : key rise -> MARK (new char). dur reaches 7D -> push 0x20 once -> IDLE.
//  - Char code: idx = (1<<sym_len)|sym_bits (sentinel-prefixed); combinational ROM maps A-Z, 0-9 to ASCII;
//    unmapped idx or sym_err -> '?' (0x3F). Push occurs the clk after the threshold tick; out_valid rises the clk after push.
//  - Threshold comparisons use equality on the tick that reaches them: each push fires exactly once per gap.
//  - FIFO: push when full and no pop same cycle -> byte dropped, overrun=1. Push and pop same cycle when full -> both
//    performed, no overrun. Pop when empty ignored. Pointers wrap modulo FIFO_DEPTH.
//  - clr_overrun and a new overrun event in the same cycle -> overrun stays 1.
//  - enable=0: FSM forced IDLE, symbol cleared, dur held 0; debouncer/FIFO keep running. Re-enable while key=1
//    waits for next rise (no partial mark decoded).
//  - A mark with dur saturated is a dash; a key held forever produces nothing until released.
// CONFIGURATION
//  MORSE_RX_STATS_EN defined: adds ports char_count out 16 (every pushed non-space char, wraps at 16'hFFFF) and
//    err_count out 8 (pushed '?' chars, saturates at 8'hFF); both reset to 0.
//  Not defined: ports and counters absent; decode behaviour identical.
// TESTING  (TICK_DIV=4, DEBOUNCE_TICKS=2, dot_ticks=10, enable=1)
//  1. mark 10, space 10, mark 30, space 40 ticks -> one byte 0x41 'A'; busy returns to 0 after 7D space only.
//  2. "SOS" with 10-tick intra gaps, 30-tick char gaps, then 80-tick space -> 0x53,0x4F,0x53,0x20 in order.
//  3. seven 10-tick dots then 30-tick gap -> 0x3F; with MORSE_RX_STATS_EN err_count=1, char_count=1.
//  4. out_ready=0, send 17 'E' chars -> 16 bytes 0x45 queued, overrun=1; drain 16 with out_ready=1,
//     out_valid falls; clr_overrun pulse -> overrun=0.
//  5. 1-tick key pulse amid idle -> no FIFO push, busy stays 0; 12-tick pulse + 30 gap -> 'E' (0x45).
//  6. assert rst mid-mark of a dash -> all outputs 0 immediately; after release, mark 10 + space 30 -> only 'E'.

Source files
------------

// File: rtl/morse_rx_decoder.sv
// Times on/off keyed marks and spaces against a dot length and decodes to ASCII.
// Define MORSE_RX_STATS_EN to add the char_count/err_count outputs.
module morse_rx_decoder #(
  parameter int TICK_DIV       = 36000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_in,
  input  logic        enable,
  input  logic [11:0] dot_ticks,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun,
  input  logic        clr_overrun,
  output logic        busy
`ifdef MORSE_RX_STATS_EN
  ,
  output logic [15:0] char_count,
  output logic [7:0]  err_count
`endif
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, MARK, GAP, WORDGAP} state_t;

  state_t state, state_n;

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [1:0]    sync;
  logic          key_s;
  logic          key_db;
  logic [DW-1:0] db_cnt;
  logic          db_edge;
  logic          rise;
  logic          fall;

  logic [15:0] dot;
  logic [15:0] th2;
  logic [15:0] th3;
  logic [15:0] th7;
  logic [15:0] dur;
  logic [15:0] dur_inc;
  logic        hit3;
  logic        hit7;
  logic        is_dash;

  logic [5:0] sym_bits;
  logic [2:0] sym_len;
  logic       sym_err;
  logic [6:0] idx;
  logic [7:0] rom_char;
  logic [7:0] char_code;

  logic       sym_clr;
  logic       sym_app;
  logic       push_n;
  logic       push_sp;
  logic       push_q;
  logic [7:0] push_byte;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        pop;
  logic        wr_en;
  logic        ovf;

  assign tick = (pre_cnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else pre_cnt <= pre_cnt + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b00;
    else sync <= {sync[0], key_in};
  end

  assign key_s = sync[1];

  // Level change accepted on the Nth consecutive differing tick sample
  assign db_edge = tick && (key_s != key_db) &&
                   (db_cnt == DW'(DEBOUNCE_TICKS - 1));
  assign rise = db_edge & key_s;
  assign fall = db_edge & ~key_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_db <= 1'b0;
      db_cnt <= '0;
    end else if (tick) begin
      if (key_s == key_db) begin
        db_cnt <= '0;
      end else if (db_edge) begin
        key_db <= key_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  assign dot = (dot_ticks == 12'd0) ? 16'd1 : {4'd0, dot_ticks};
  assign th2 = dot << 1;
  assign th3 = th2 + dot;
  assign th7 = (dot << 3) - dot;

  // dur_inc is the length of the current run including this tick
  assign dur_inc = (&dur) ? dur : dur + 16'd1;
  assign hit3    = tick && (dur_inc == th3);
  assign hit7    = tick && (dur_inc == th7);
  assign is_dash = (dur_inc >= th2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dur <= '0;
    else if (!enable || db_edge) dur <= '0;
    else if (tick) dur <= dur_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    push_n  = 1'b0;
    push_sp = 1'b0;
    sym_clr = 1'b0;
    sym_app = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) state_n = MARK;
      end
      MARK: begin
        if (fall) begin
          sym_app = 1'b1;
          state_n = GAP;
        end
      end
      GAP: begin
        if (hit3) begin
          push_n  = 1'b1;
          sym_clr = 1'b1;
          state_n = rise ? MARK : WORDGAP;
        end else if (rise) begin
          state_n = MARK;
        end
      end
      WORDGAP: begin
        if (hit7) begin
          push_n  = 1'b1;
          push_sp = 1'b1;
          state_n = rise ? MARK : IDLE;
        end else if (rise) begin
          state_n = MARK;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!enable) begin
      state_n = IDLE;
      push_n  = 1'b0;
      sym_clr = 1'b1;
      sym_app = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_bits <= '0;
      sym_len  <= '0;
      sym_err  <= 1'b0;
    end else if (sym_clr) begin
      sym_bits <= '0;
      sym_len  <= '0;
      sym_err  <= 1'b0;
    end else if (sym_app) begin
      if (sym_len == 3'd6) begin
        sym_err <= 1'b1;
      end else begin
        sym_bits <= {sym_bits[4:0], is_dash};
        sym_len  <= sym_len + 3'd1;
      end
    end
  end

  // Sentinel bit above the elements makes every length unique
  assign idx = (7'd1 << sym_len) | {1'b0, sym_bits};

  always_comb begin
    rom_char = 8'h3F;
    case (idx)
      7'd2:  rom_char = 8'h45;
      7'd3:  rom_char = 8'h54;
      7'd4:  rom_char = 8'h49;
      7'd5:  rom_char = 8'h41;
      7'd6:  rom_char = 8'h4E;
      7'd7:  rom_char = 8'h4D;
      7'd8:  rom_char = 8'h53;
      7'd9:  rom_char = 8'h55;
      7'd10: rom_char = 8'h52;
      7'd11: rom_char = 8'h57;
      7'd12: rom_char = 8'h44;
      7'd13: rom_char = 8'h4B;
      7'd14: rom_char = 8'h47;
      7'd15: rom_char = 8'h4F;
      7'd16: rom_char = 8'h48;
      7'd17: rom_char = 8'h56;
      7'd18: rom_char = 8'h46;
      7'd20: rom_char = 8'h4C;
      7'd22: rom_char = 8'h50;
      7'd23: rom_char = 8'h4A;
      7'd24: rom_char = 8'h42;
      7'd25: rom_char = 8'h58;
      7'd26: rom_char = 8'h43;
      7'd27: rom_char = 8'h59;
      7'd28: rom_char = 8'h5A;
      7'd29: rom_char = 8'h51;
      7'd32: rom_char = 8'h35;
      7'd33: rom_char = 8'h34;
      7'd35: rom_char = 8'h33;
      7'd39: rom_char = 8'h32;
      7'd47: rom_char = 8'h31;
      7'd48: rom_char = 8'h36;
      7'd56: rom_char = 8'h37;
      7'd60: rom_char = 8'h38;
      7'd62: rom_char = 8'h39;
      7'd63: rom_char = 8'h30;
      default: rom_char = 8'h3F;
    endcase
  end

  assign char_code = sym_err ? 8'h3F : rom_char;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_q    <= 1'b0;
      push_byte <= '0;
    end else begin
      push_q    <= push_n;
      push_byte <= push_sp ? 8'h20 : char_code;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = out_valid & out_ready;
  assign wr_en = push_q && (!full || pop);
  assign ovf   = push_q && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun <= 1'b0;
    else if (ovf) overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

  assign out_valid = !empty;
  assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign busy      = (state != IDLE);

`ifdef MORSE_RX_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_count <= '0;
      err_count  <= '0;
    end else if (push_q) begin
      if (push_byte != 8'h20) char_count <= char_count + 16'd1;
      if (push_byte == 8'h3F && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Bench for morse_rx_decoder: directed scenarios plus randomized traffic
// checked against a pattern-string reference model.
module tb_morse_rx_decoder;

  localparam int TDIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_in;
  logic        enable;
  logic [11:0] dot_ticks;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic        clr_overrun;
  logic        busy;
`ifdef MORSE_RX_STATS_EN
  logic [15:0] char_count;
  logic [7:0]  err_count;
`endif

  int errors = 0;
  int checks = 0;

  byte   got[$];
  byte   exp_q[$];
  int    seg_n[$];
  bit    seg_l[$];
  string pats[36];
  string chars = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

  morse_rx_decoder #(
    .TICK_DIV(TDIV),
    .DEBOUNCE_TICKS(2),
    .FIFO_DEPTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_in(key_in),
    .enable(enable),
    .dot_ticks(dot_ticks),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun(overrun),
    .clr_overrun(clr_overrun),
    .busy(busy)
`ifdef MORSE_RX_STATS_EN
    ,
    .char_count(char_count),
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got.push_back(out_data);
  end

  task automatic add(input bit l, input int n);
    if (seg_l.size() > 0 && seg_l[$] == l) seg_n[$] = seg_n[$] + n;
    else begin
      seg_l.push_back(l);
      seg_n.push_back(n);
    end
  endtask

  task automatic clear_all();
    seg_l.delete();
    seg_n.delete();
    exp_q.delete();
    got.delete();
  endtask

  task automatic play();
    for (int i = 0; i < seg_n.size(); i++) begin
      key_in = seg_l[i];
      repeat (seg_n[i] * TDIV) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic idle_ticks(input int n);
    repeat (n * TDIV) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic byte lookup(input string p);
    if (p.len() > 6) return 8'h3F;
    for (int i = 0; i < 36; i++)
      if (pats[i] == p) return chars[i];
    return 8'h3F;
  endfunction

  // Decode the segment list from the timing rules alone
  task automatic model(input int d);
    string p;
    p = "";
    for (int i = 0; i < seg_n.size(); i++) begin
      if (seg_l[i]) begin
        if (seg_n[i] < 2 * d) p = {p, "."};
        else p = {p, "-"};
      end else if (p.len() > 0 && seg_n[i] >= 3 * d) begin
        exp_q.push_back(lookup(p));
        p = "";
        if (seg_n[i] >= 7 * d) exp_q.push_back(8'h20);
      end
    end
  endtask

  task automatic test_reset();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", out_valid);
    end
    checks++;
    if (out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got %02h want 00", out_data);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_overrun got %b want 0", overrun);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
`ifdef MORSE_RX_STATS_EN
    checks++;
    if (char_count !== 16'd0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_stats got %0d/%0d want 0/0",
               char_count, err_count);
    end
`endif
    rst = 1'b0;
    idle_ticks(10);
  endtask

  task automatic test_seven_dots();
    clear_all();
    add(0, 5);
    for (int i = 0; i < 7; i++) begin
      add(1, 10);
      add(0, 10);
    end
    add(0, 70);
    play();
    checks++;
    if (got.size() != 2) begin
      errors++;
      $display("FAIL dots7_count got %0d want 2", got.size());
    end else begin
      checks++;
      if (got[0] !== 8'h3F || got[1] !== 8'h20) begin
        errors++;
        $display("FAIL dots7_bytes got %02h %02h want 3f 20",
                 got[0], got[1]);
      end
    end
`ifdef MORSE_RX_STATS_EN
    checks++;
    if (err_count !== 8'd1 || char_count !== 16'd1) begin
      errors++;
      $display("FAIL dots7_stats got %0d/%0d want err 1 char 1",
               err_count, char_count);
    end
`endif
  endtask

  task automatic test_letter_a();
    clear_all();
    add(0, 5);
    add(1, 10);
    add(0, 10);
    add(1, 30);
    add(0, 40);
    play();
    checks++;
    if (got.size() != 1 || got[0] !== 8'h41) begin
      errors++;
      $display("FAIL a_char got n=%0d b=%02h want n=1 b=41",
               got.size(), (got.size() > 0) ? got[0] : 8'h00);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL a_busy_gap got %b want 1", busy);
    end
    idle_ticks(40);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL a_busy_idle got %b want 0", busy);
    end
    checks++;
    if (got.size() != 2 || got[$] !== 8'h20) begin
      errors++;
      $display("FAIL a_space got n=%0d want n=2 last 20", got.size());
    end
  endtask

  task automatic test_sos();
    clear_all();
    add(0, 5);
    for (int c = 0; c < 3; c++) begin
      for (int e = 0; e < 3; e++) begin
        add(1, (c == 1) ? 30 : 10);
        if (e < 2) add(0, 10);
      end
      add(0, (c == 2) ? 80 : 30);
    end
    exp_q = '{8'h53, 8'h4F, 8'h53, 8'h20};
    play();
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL sos_count got %0d want %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL sos_byte%0d got %02h want %02h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overrun();
    clear_all();
    out_ready = 1'b0;
    add(0, 5);
    for (int i = 0; i < 17; i++) begin
      add(1, 10);
      add(0, 30);
    end
    add(0, 50);
    play();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h45) begin
      errors++;
      $display("FAIL ovf_head got v=%b d=%02h want v=1 d=45",
               out_valid, out_data);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag got %b want 1", overrun);
    end
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (got.size() != 16) begin
      errors++;
      $display("FAIL ovf_drain_count got %0d want 16", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 8'h45) begin
        errors++;
        $display("FAIL ovf_byte%0d got %02h want 45", i, got[i]);
      end
    end
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after_drain got v=%b o=%b want v=0 o=1",
               out_valid, overrun);
    end
    clr_overrun = 1'b1;
    @(posedge clk);
    #1;
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got %b want 0", overrun);
    end
  endtask

  task automatic test_glitch();
    bit saw_busy;
    clear_all();
    saw_busy = 1'b0;
    key_in = 1'b1;
    idle_ticks(1);
    key_in = 1'b0;
    repeat (20 * TDIV) begin
      @(posedge clk);
      #1;
      if (busy) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy !== 1'b0 || got.size() != 0) begin
      errors++;
      $display("FAIL glitch got busy=%b n=%0d want busy=0 n=0",
               saw_busy, got.size());
    end
    add(1, 12);
    add(0, 80);
    play();
    checks++;
    if (got.size() != 2 || got[0] !== 8'h45 || got[1] !== 8'h20) begin
      errors++;
      $display("FAIL glitch_e got n=%0d want 45 20", got.size());
    end
  endtask

  task automatic test_enable();
    clear_all();
    add(1, 10);
    add(0, 10);
    add(1, 5);
    play();
    enable = 1'b0;
    idle_ticks(5);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL en_busy got %b want 0", busy);
    end
    enable = 1'b1;
    idle_ticks(5);
    key_in = 1'b0;
    idle_ticks(80);
    checks++;
    if (got.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL en_discard got n=%0d busy=%b want n=0 busy=0",
               got.size(), busy);
    end
    clear_all();
    add(1, 10);
    add(0, 80);
    play();
    checks++;
    if (got.size() != 2 || got[0] !== 8'h45) begin
      errors++;
      $display("FAIL en_resume got n=%0d want 2 starting 45", got.size());
    end
  endtask

  task automatic test_reset_mid_mark();
    clear_all();
    out_ready = 1'b0;
    add(1, 10);
    add(0, 40);
    add(1, 15);
    play();
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got busy=%b v=%b want 1 1", busy, out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 ||
        out_data !== 8'h00 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outs got b=%b v=%b d=%02h o=%b want all 0",
               busy, out_valid, out_data, overrun);
    end
    key_in = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    clear_all();
    add(0, 10);
    add(1, 10);
    add(0, 80);
    play();
    checks++;
    if (got.size() != 2 || got[0] !== 8'h45 || got[1] !== 8'h20) begin
      errors++;
      $display("FAIL rstmid_after got n=%0d want 45 20", got.size());
    end
  endtask

  task automatic test_random();
    int    d;
    int    nel;
    string p;
    for (int r = 0; r < 3; r++) begin
      d = (r == 0) ? 10 : int'($urandom_range(12, 3));
      dot_ticks = 12'(d);
      clear_all();
      add(0, 5);
      for (int c = 0; c < 8; c++) begin
        if ($urandom_range(1, 0) == 1) begin
          p = pats[$urandom_range(35, 0)];
        end else begin
          p = "";
          nel = $urandom_range(7, 1);
          repeat (nel) begin
            if ($urandom_range(1, 0) == 1) p = {p, "-"};
            else p = {p, "."};
          end
        end
        for (int e = 0; e < p.len(); e++) begin
          if (p[e] == 8'h2E) add(1, $urandom_range(2 * d - 1, 2));
          else add(1, $urandom_range(4 * d, 2 * d));
          if (e < p.len() - 1) add(0, $urandom_range(3 * d - 1, 2));
        end
        case ($urandom_range(2, 0))
          0: add(0, $urandom_range(7 * d - 1, 3 * d));
          1: add(0, $urandom_range(8 * d, 7 * d));
          default: add(0, 3 * d);
        endcase
      end
      add(0, 8 * d + 10);
      model(d);
      play();
      checks++;
      if (got.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_count got %0d want %0d",
                 r, got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand%0d_byte%0d got %02h want %02h",
                   r, i, got[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    key_in = 1'b0;
    enable = 1'b1;
    out_ready = 1'b1;
    clr_overrun = 1'b0;
    dot_ticks = 12'd10;
    pats = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
             "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
             "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
             "-.--", "--..", "-----", ".----", "..---", "...--",
             "....-", ".....", "-....", "--...", "---..", "----."};
    test_reset();
    test_seven_dots();
    test_letter_a();
    test_sos();
    test_overrun();
    test_glitch();
    test_enable();
    test_reset_mid_mark();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
